// File: rtl/spcpu_fetch_unit.sv
// spcpu_fetch_unit
//
// Decoupled instruction fetch front end. Halfwords are prefetched from
// memory into a small circular queue and assembled into 16-bit or 32-bit
// instructions at the queue head for the decode stage.
//
// Parameters
//   ADDR_WIDTH      byte-address width; fetch and head PCs wrap modulo 2^ADDR_WIDTH
//   QUEUE_DEPTH     prefetch queue depth in halfwords (power of two, >= 2)
//   MAX_OUTSTANDING granted requests allowed to await a response (>= 1)
//   RESET_PC        first fetch address after reset (bit 0 forced to 0)
//   LONG_MASK/MATCH halfword h starts a 32-bit instruction iff (h & LONG_MASK) == LONG_MATCH
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   mem_req/mem_addr    fetch request and its halfword-aligned byte address
//   mem_gnt             request accepted this cycle (only meaningful with mem_req)
//   mem_rvalid/rdata    in-order response halfword, >= 1 cycle after grant
//   redirect/_pc        flush everything and restart fetch at redirect_pc
//   instr_valid/ready   instruction handoff to decode
//   instr_out           {first halfword, second halfword or 16'h0}
//   instr_is_32         head instruction is 32-bit
//   instr_pc            byte address of the head instruction
//
// Handshakes: a transfer happens on a rising edge where both sides of a pair
// are high (mem_req & mem_gnt for requests, instr_valid & instr_ready for
// instructions). mem_req and instr_valid never depend combinationally on
// mem_gnt or instr_ready. mem_rvalid has no back-pressure: every response is
// taken in the cycle it is presented.

module spcpu_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH      = 16,
  parameter int unsigned           QUEUE_DEPTH     = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [15:0]           LONG_MASK       = 16'hf000,
  parameter logic [15:0]           LONG_MATCH      = 16'hf000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [15:0]           mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_out,
  output logic                  instr_is_32,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  // Wide enough for occupancy (0..QUEUE_DEPTH) and outstanding/stale counts.
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] HW_MASK  = ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] START_PC = RESET_PC & HW_MASK;
  localparam logic [CNT_W:0]        QD_SUM   = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]      MO_CNT   = CNT_W'(MAX_OUTSTANDING);

  // Architectural state
  logic [15:0]           q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occupancy;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      stale;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] head_pc;

  // Combinational decode of the current cycle
  logic [15:0]           head_hw;
  logic [15:0]           second_hw;
  logic                  show_head;
  logic                  head_long;
  logic                  have_second;
  logic [CNT_W:0]        credit_used;
  logic                  issue;
  logic                  resp_ok;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic [CNT_W-1:0]      pop_cnt;
  logic [PTR_W-1:0]      pop_step;
  logic [ADDR_WIDTH-1:0] pc_step;
  logic [ADDR_WIDTH-1:0] redirect_target;

  always_comb begin
    head_hw         = q_mem[rd_ptr];
    second_hw       = q_mem[rd_ptr + PTR_W'(1)];
    show_head       = !reset && (occupancy != '0);
    head_long       = show_head && ((head_hw & LONG_MASK) == LONG_MATCH);
    have_second     = occupancy >= CNT_W'(2);
    redirect_target = redirect_pc & HW_MASK;

    // Credits: a request is only issued if its response is guaranteed a
    // queue slot, so responses never need back-pressure.
    credit_used = {1'b0, occupancy} + {1'b0, outstanding};
    mem_req     = !reset && !redirect && (credit_used < QD_SUM)
                  && (outstanding < MO_CNT);
    mem_addr    = reset ? START_PC : fetch_pc;
    issue       = mem_req && mem_gnt;

    // A response with nothing outstanding is a protocol error and ignored.
    // Responses to requests issued before a redirect are counted in stale.
    resp_ok = mem_rvalid && (outstanding != '0);
    drop    = resp_ok && (stale != '0);
    push    = resp_ok && (stale == '0);

    // A long head needs its second halfword in the queue before handoff.
    instr_valid = !redirect && show_head && (!head_long || have_second);
    instr_is_32 = head_long;
    instr_pc    = reset ? START_PC : head_pc;
    instr_out   = '0;
    if (show_head) begin
      instr_out = {head_hw, (head_long && have_second) ? second_hw : 16'h0000};
    end

    pop      = instr_valid && instr_ready;
    pop_cnt  = '0;
    pop_step = PTR_W'(1);
    pc_step  = ADDR_WIDTH'(2);
    if (head_long) begin
      pop_step = PTR_W'(2);
      pc_step  = ADDR_WIDTH'(4);
    end
    if (pop) begin
      pop_cnt = head_long ? CNT_W'(2) : CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      stale       <= '0;
      fetch_pc    <= START_PC;
      head_pc     <= START_PC;
    end else if (redirect) begin
      // Everything still in flight (except a response landing right now,
      // which is discarded) must be thrown away when it returns.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= outstanding - CNT_W'(resp_ok);
      stale       <= outstanding - CNT_W'(resp_ok);
      fetch_pc    <= redirect_target;
      head_pc     <= redirect_target;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(2);
      end
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp_ok);
      if (drop) begin
        stale <= stale - CNT_W'(1);
      end
      if (push) begin
        q_mem[wr_ptr] <= mem_rdata;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + pop_step;
        head_pc <= head_pc + pc_step;
      end
      occupancy <= occupancy + CNT_W'(push) - pop_cnt;
    end
  end

endmodule

// File: tb/tb_spcpu_fetch_unit.sv
// Self-checking bench for spcpu_fetch_unit: a 16-bit-address instance with a
// configurable-latency memory model and an 8-bit-address instance for the
// address-wrap case. Expected instructions and request addresses are queued
// by the stimulus and checked by independent monitors.

module tb_spcpu_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (ADDR_WIDTH = 16)
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic        instr_is_32;
  logic [15:0] instr_pc;

  // DUT B (ADDR_WIDTH = 8)
  logic        b_reset;
  logic        b_mem_req;
  logic [7:0]  b_mem_addr;
  logic        b_mem_gnt;
  logic        b_mem_rvalid;
  logic [15:0] b_mem_rdata;
  logic        b_redirect;
  logic [7:0]  b_redirect_pc;
  logic        b_instr_valid;
  logic        b_instr_ready;
  logic [31:0] b_instr_out;
  logic        b_instr_is_32;
  logic [7:0]  b_instr_pc;

  spcpu_fetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_is_32(instr_is_32), .instr_pc(instr_pc)
  );

  spcpu_fetch_unit #(.ADDR_WIDTH(8)) dut_b (
    .clk(clk), .reset(b_reset),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_gnt(b_mem_gnt),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
    .instr_out(b_instr_out), .instr_is_32(b_instr_is_32), .instr_pc(b_instr_pc)
  );

  // ---------------- memory models ----------------
  typedef struct {
    logic [15:0] data;
    int          due;
  } pend_t;

  logic [15:0] mem_img [256];
  logic [15:0] mem_b   [128];
  pend_t       pend_a[$];
  pend_t       pend_b[$];
  int          lat        = 1;
  int          gnt_budget = 0;
  int          b_budget   = 0;
  logic [15:0] hold_addr  = 16'hffff;
  int          hold_extra = 0;

  assign mem_gnt   = (gnt_budget > 0);
  assign b_mem_gnt = (b_budget > 0);

  // In-order responses; a grant in cycle c is answered in cycle c+lat
  // (plus hold_extra for hold_addr), never overtaking an earlier response.
  initial begin : mem_model_a
    pend_t p;
    int    cyc;
    int    due;
    cyc = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    forever begin
      @(posedge clk);
      if (mem_req && mem_gnt) begin
        due = cyc + lat + ((mem_addr == hold_addr) ? hold_extra : 0);
        if (pend_a.size() != 0 && pend_a[$].due >= due) due = pend_a[$].due + 1;
        p.data = mem_img[mem_addr[8:1]];
        p.due  = due;
        pend_a.push_back(p);
        gnt_budget <= gnt_budget - 1;
      end
      if (pend_a.size() != 0 && pend_a[0].due <= cyc + 1) begin
        p = pend_a.pop_front();
        mem_rvalid <= 1'b1;
        mem_rdata  <= p.data;
      end else begin
        mem_rvalid <= 1'b0;
        mem_rdata  <= 16'h0;
      end
      cyc++;
    end
  end

  initial begin : mem_model_b
    pend_t p;
    int    cyc;
    cyc = 0;
    b_mem_rvalid = 1'b0;
    b_mem_rdata  = 16'h0;
    forever begin
      @(posedge clk);
      if (b_mem_req && b_mem_gnt) begin
        p.data = mem_b[b_mem_addr[7:1]];
        p.due  = cyc + 1;
        pend_b.push_back(p);
        b_budget <= b_budget - 1;
      end
      if (pend_b.size() != 0 && pend_b[0].due <= cyc + 1) begin
        p = pend_b.pop_front();
        b_mem_rvalid <= 1'b1;
        b_mem_rdata  <= p.data;
      end else begin
        b_mem_rvalid <= 1'b0;
        b_mem_rdata  <= 16'h0;
      end
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          grant_cnt = 0;
  logic [48:0] exp_q[$];        // {is_32, pc[15:0], instr[31:0]}
  logic [15:0] exp_addr_q[$];
  logic [40:0] b_exp_q[$];      // {is_32, pc[7:0], instr[31:0]}
  logic [7:0]  b_exp_addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic expect_instr(input logic [15:0] pc, input logic [31:0] ins, input logic is32);
    exp_q.push_back({is32, pc, ins});
  endtask

  initial begin : monitor_a
    forever begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) unexpected("instr", 64'({instr_is_32, instr_pc, instr_out}));
        else check("instr", 64'({instr_is_32, instr_pc, instr_out}), 64'(exp_q.pop_front()));
      end
      if (mem_req && mem_gnt) begin
        grant_cnt++;
        if (exp_addr_q.size() == 0) unexpected("mem_addr", 64'(mem_addr));
        else check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
    end
  end

  initial begin : monitor_b
    forever begin
      @(negedge clk);
      if (b_instr_valid && b_instr_ready) begin
        if (b_exp_q.size() == 0) unexpected("b_instr", 64'({b_instr_is_32, b_instr_pc, b_instr_out}));
        else check("b_instr", 64'({b_instr_is_32, b_instr_pc, b_instr_out}), 64'(b_exp_q.pop_front()));
      end
      if (b_mem_req && b_mem_gnt) begin
        if (b_exp_addr_q.size() == 0) unexpected("b_mem_addr", 64'(b_mem_addr));
        else check("b_mem_addr", 64'(b_mem_addr), 64'(b_exp_addr_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},     64'(mem_req),     64'(0));
    check({tag, "_mem_addr"},    64'(mem_addr),    64'(0));
    check({tag, "_instr_valid"}, 64'(instr_valid), 64'(0));
    check({tag, "_instr_is_32"}, 64'(instr_is_32), 64'(0));
    check({tag, "_instr_out"},   64'(instr_out),   64'(0));
    check({tag, "_instr_pc"},    64'(instr_pc),    64'(0));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_instr_q_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_addr_q_empty"},  64'(exp_addr_q.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; instr_ready = 1'b0;
    b_reset = 1'b1; b_redirect = 1'b0; b_redirect_pc = 8'h0; b_instr_ready = 1'b0;

    // Test 1: reset values, basic 16/32-bit assembly and first-valid latency
    mem_img[0] = 16'h1234; mem_img[1] = 16'hf001;
    mem_img[2] = 16'habcd; mem_img[3] = 16'h0005;
    lat = 1; gnt_budget = 4; instr_ready = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004); exp_addr_q.push_back(16'h0006);
    expect_instr(16'h0000, 32'h1234_0000, 1'b0);
    expect_instr(16'h0002, 32'hf001_abcd, 1'b1);
    expect_instr(16'h0006, 32'h0005_0000, 1'b0);
    reset = 1'b0; #1;
    check("cycle0_mem_req",  64'(mem_req),  64'(1));
    check("cycle0_mem_addr", 64'(mem_addr), 64'(16'h0000));
    tick(1); check("cycle1_valid", 64'(instr_valid), 64'(0));
    tick(1); check("cycle2_valid", 64'(instr_valid), 64'(1));
    tick(1); check("cycle3_long_wait", 64'(instr_valid), 64'(0));
    tick(10);
    check_drained("t1");

    // Test 2: back-pressure fills the queue, then requests resume
    reset = 1'b1; tick(2);
    mem_img[0] = 16'h0011; mem_img[1] = 16'h0022; mem_img[2] = 16'h0033;
    mem_img[3] = 16'h0044; mem_img[4] = 16'h0055;
    gnt_budget = 5; instr_ready = 1'b0; grant_cnt = 0;
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(16'(2 * i));
    reset = 1'b0;
    tick(8);
    check("t2_grants_stalled", 64'(grant_cnt), 64'(4));
    check("t2_req_stalled", 64'(mem_req), 64'(0));
    check("t2_head_valid", 64'(instr_valid), 64'(1));
    expect_instr(16'h0000, 32'h0011_0000, 1'b0);
    expect_instr(16'h0002, 32'h0022_0000, 1'b0);
    expect_instr(16'h0004, 32'h0033_0000, 1'b0);
    expect_instr(16'h0006, 32'h0044_0000, 1'b0);
    expect_instr(16'h0008, 32'h0055_0000, 1'b0);
    instr_ready = 1'b1;
    tick(1); check("t2_req_restart", 64'(mem_req), 64'(1));
    tick(10);
    check("t2_grants_total", 64'(grant_cnt), 64'(5));
    check_drained("t2");

    // Test 3: latency 3, redirect with two requests outstanding
    reset = 1'b1; tick(2);
    lat = 3; gnt_budget = 2; instr_ready = 1'b1;
    mem_img[0] = 16'h0777; mem_img[1] = 16'h0888;
    mem_img[128] = 16'h0aaa; mem_img[129] = 16'h0bbb;
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0102);
    expect_instr(16'h0100, 32'h0aaa_0000, 1'b0);
    expect_instr(16'h0102, 32'h0bbb_0000, 1'b0);
    reset = 1'b0;
    tick(2);
    check("t3_req_credit_stall", 64'(mem_req), 64'(0));
    redirect = 1'b1; redirect_pc = 16'h0101; gnt_budget = 2; #1;
    check("t3_redirect_no_valid", 64'(instr_valid), 64'(0));
    tick(1); redirect = 1'b0; #1;
    check("t3_new_fetch_addr", 64'(mem_addr), 64'(16'h0100));
    tick(14);
    check_drained("t3");

    // Test 4: long head whose second halfword is 5 cycles late
    reset = 1'b1; tick(2);
    lat = 1; gnt_budget = 3; hold_addr = 16'h0004; hold_extra = 5; instr_ready = 1'b1;
    mem_img[0] = 16'h0123; mem_img[1] = 16'hf555; mem_img[2] = 16'h6666;
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004);
    expect_instr(16'h0000, 32'h0123_0000, 1'b0);
    expect_instr(16'h0002, 32'hf555_6666, 1'b1);
    reset = 1'b0;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      check("t4_long_head_waits", 64'(instr_valid), 64'(0));
      tick(1);
    end
    check("t4_pair_valid", 64'(instr_valid), 64'(1));
    check("t4_pair_is_32", 64'(instr_is_32), 64'(1));
    tick(1); check("t4_pair_single_pop", 64'(instr_valid), 64'(0));
    hold_extra = 0;
    tick(8);
    check_drained("t4");

    // Test 5: 8-bit address wrap with a 32-bit instruction at 8'hfe
    mem_b[127] = 16'hf0ab; mem_b[0] = 16'h1357;
    b_budget = 2; b_instr_ready = 1'b1;
    b_exp_addr_q.push_back(8'hfe); b_exp_addr_q.push_back(8'h00);
    b_exp_q.push_back({1'b1, 8'hfe, 32'hf0ab_1357});
    b_reset = 1'b0; b_redirect = 1'b1; b_redirect_pc = 8'hfe; #1;
    check("t5_redirect_no_req", 64'(b_mem_req), 64'(0));
    tick(1); b_redirect = 1'b0;
    tick(3);
    check("t5_wrap_valid", 64'(b_instr_valid), 64'(1));
    tick(1);
    check("t5_wrapped_pc", 64'(b_instr_pc), 64'(8'h02));
    tick(6);
    check("t5_instr_q_empty", 64'(b_exp_q.size()), 64'(0));
    check("t5_addr_q_empty", 64'(b_exp_addr_q.size()), 64'(0));

    // Test 6: reset with 3 queued halfwords and 1 outstanding; late rvalid
    reset = 1'b1; tick(2);
    lat = 1; gnt_budget = 4; hold_addr = 16'h0006; hold_extra = 4; instr_ready = 1'b0;
    mem_img[0] = 16'h0a01; mem_img[1] = 16'h0a02;
    mem_img[2] = 16'h0a03; mem_img[3] = 16'h0a06;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(16'(2 * i));
    reset = 1'b0;
    tick(4);
    check("t6_queue_loaded", 64'(instr_valid), 64'(1));
    reset = 1'b1; gnt_budget = 0;
    tick(1);
    check_reset_outputs("t6_reset");
    tick(1);
    reset = 1'b0; instr_ready = 1'b1; #1;
    check("t6_restart_req",  64'(mem_req),  64'(1));
    check("t6_restart_addr", 64'(mem_addr), 64'(16'h0000));
    tick(3);
    hold_extra = 0;
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0002);
    expect_instr(16'h0000, 32'h0a01_0000, 1'b0);
    expect_instr(16'h0002, 32'h0a02_0000, 1'b0);
    gnt_budget = 2;
    tick(10);
    check_drained("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
